// File: rtl/c5_mac_8bit_x3.sv
// c5_mac_8bit_x3: pipelined three-term multiply-accumulate.
// result = a0*b0 + a1*b1 + a2*b2. The operands are registered on one edge,
// and the sum is registered on the next edge. A new operand set is accepted
// every cycle. SIGNED selects two's-complement (1) or unsigned (0) operands.
// RESULT_WIDTH must be at least A_WIDTH+B_WIDTH+2 so the three-term sum
// cannot overflow.
module c5_mac_8bit_x3 #(
  parameter int A_WIDTH      = 8,
  parameter int B_WIDTH      = 8,
  parameter int RESULT_WIDTH = 32,
  parameter int SIGNED       = 1
) (
  input  logic                    clock0,
  input  logic                    resetn,
  input  logic [A_WIDTH-1:0]      dataa_0,
  input  logic [A_WIDTH-1:0]      dataa_1,
  input  logic [A_WIDTH-1:0]      dataa_2,
  input  logic [B_WIDTH-1:0]      datab_0,
  input  logic [B_WIDTH-1:0]      datab_1,
  input  logic [B_WIDTH-1:0]      datab_2,
  output logic [RESULT_WIDTH-1:0] result
);

  // The products are formed at full result width. Both operands are first
  // extended to RESULT_WIDTH, using sign or zero extension according to SIGNED.
  // The low RESULT_WIDTH bits of that product equal the exact product,
  // signed or unsigned. The sum therefore needs no separate extension step.
  function automatic logic [RESULT_WIDTH-1:0] ext_a(input logic [A_WIDTH-1:0] v);
    logic [RESULT_WIDTH-1:0] r;
    if (SIGNED != 0) begin
      r = {{(RESULT_WIDTH-A_WIDTH){v[A_WIDTH-1]}}, v};
    end else begin
      r = {{(RESULT_WIDTH-A_WIDTH){1'b0}}, v};
    end
    return r;
  endfunction

  function automatic logic [RESULT_WIDTH-1:0] ext_b(input logic [B_WIDTH-1:0] v);
    logic [RESULT_WIDTH-1:0] r;
    if (SIGNED != 0) begin
      r = {{(RESULT_WIDTH-B_WIDTH){v[B_WIDTH-1]}}, v};
    end else begin
      r = {{(RESULT_WIDTH-B_WIDTH){1'b0}}, v};
    end
    return r;
  endfunction

  // Stage-1 operand registers.
  logic [A_WIDTH-1:0] a0_q, a1_q, a2_q;
  logic [B_WIDTH-1:0] b0_q, b1_q, b2_q;

  // Stage-2 sum register, with its next-state value.
  logic [RESULT_WIDTH-1:0] result_q, result_d;
  logic [RESULT_WIDTH-1:0] p0_s, p1_s, p2_s;

  // Stage 1: sample all six operands. An async reset clears them to zero.
  always_ff @(posedge clock0 or negedge resetn) begin
    if (!resetn) begin
      a0_q <= {A_WIDTH{1'b0}};
      a1_q <= {A_WIDTH{1'b0}};
      a2_q <= {A_WIDTH{1'b0}};
      b0_q <= {B_WIDTH{1'b0}};
      b1_q <= {B_WIDTH{1'b0}};
      b2_q <= {B_WIDTH{1'b0}};
    end else begin
      a0_q <= dataa_0;
      a1_q <= dataa_1;
      a2_q <= dataa_2;
      b0_q <= datab_0;
      b1_q <= datab_1;
      b2_q <= datab_2;
    end
  end

  // Products and three-term sum, computed from the stage-1 registers.
  always_comb begin
    p0_s     = ext_a(a0_q) * ext_b(b0_q);
    p1_s     = ext_a(a1_q) * ext_b(b1_q);
    p2_s     = ext_a(a2_q) * ext_b(b2_q);
    result_d = p0_s + p1_s + p2_s;
  end

  // Stage 2: register the sum. An async reset drops the result to zero immediately.
  always_ff @(posedge clock0 or negedge resetn) begin
    if (!resetn) begin
      result_q <= {RESULT_WIDTH{1'b0}};
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_c5_mac_8bit_x3.sv
// Self-checking bench for c5_mac_8bit_x3 (default signed 8x8 -> 32 configuration).
module tb_c5_mac_8bit_x3;

  logic        clock0;
  logic        resetn;
  logic [7:0]  dataa_0, dataa_1, dataa_2;
  logic [7:0]  datab_0, datab_1, datab_2;
  logic [31:0] result;

  int n_vec;
  int n_err;

  c5_mac_8bit_x3 #(
    .A_WIDTH(8), .B_WIDTH(8), .RESULT_WIDTH(32), .SIGNED(1)
  ) dut (
    .clock0 (clock0),
    .resetn (resetn),
    .dataa_0(dataa_0),
    .dataa_1(dataa_1),
    .dataa_2(dataa_2),
    .datab_0(datab_0),
    .datab_1(datab_1),
    .datab_2(datab_2),
    .result (result)
  );

  initial clock0 = 1'b0;
  always #5 clock0 = ~clock0;

  typedef struct {
    logic [2:0][7:0] a;
    logic [2:0][7:0] b;
    logic [31:0]     exp;
  } vec_t;

  vec_t tbl[6];

  // Reference model: the plain signed dot product, computed with integer arithmetic.
  function automatic logic [31:0] ref_mac(input logic [2:0][7:0] a, input logic [2:0][7:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++) begin
      s = s + int'($signed(a[i])) * int'($signed(b[i]));
    end
    return 32'(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0][7:0] a, input logic [2:0][7:0] b);
    dataa_0 = a[0]; dataa_1 = a[1]; dataa_2 = a[2];
    datab_0 = b[0]; datab_1 = b[1]; datab_2 = b[2];
  endtask

  logic [2:0][7:0] ones;
  logic [2:0][7:0] zeros;
  logic [2:0][7:0] ra, rb;
  logic [31:0]     exp_hist[$];

  initial begin
    n_vec = 0;
    n_err = 0;
    ones  = {8'h01, 8'h01, 8'h01};
    zeros = {8'h00, 8'h00, 8'h00};

    // Directed table. Fields are ordered {lane2, lane1, lane0}.
    tbl[0] = '{a: {8'h80, 8'h80, 8'h80}, b: {8'h80, 8'h80, 8'h80}, exp: 32'h0000C000};
    tbl[1] = '{a: {8'h7F, 8'h7F, 8'h7F}, b: {8'h80, 8'h80, 8'h80}, exp: 32'hFFFF4180};
    tbl[2] = '{a: {8'h00, 8'hFD, 8'h05}, b: {8'h7F, 8'h03, 8'h04}, exp: 32'h0000000B};
    tbl[3] = '{a: {8'h7F, 8'h7F, 8'h7F}, b: {8'h7F, 8'h7F, 8'h7F}, exp: 32'h0000BD03};
    tbl[4] = '{a: {8'hFF, 8'hFF, 8'hFF}, b: {8'h01, 8'h01, 8'h01}, exp: 32'hFFFFFFFD};
    tbl[5] = '{a: {8'h00, 8'h00, 8'h00}, b: {8'h12, 8'h34, 8'h56}, exp: 32'h00000000};

    // Sequence 1: check reset state, then the 2-edge latency after release.
    resetn = 1'b0;
    drive(zeros, zeros);
    repeat (2) @(posedge clock0);
    @(negedge clock0);
    check("reset_state", result, 32'h0);
    resetn = 1'b1;
    drive(ones, ones);
    @(negedge clock0);
    check("latency_edge1", result, 32'h0);
    @(negedge clock0);
    check("latency_edge2", result, 32'h00000003);

    // Table vectors: hold each set for two edges, then sample.
    // Each set is briefly disturbed between edges. The disturbed values must not be sampled.
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].a, tbl[i].b);
      @(posedge clock0);
      #2 drive(zeros, ones);
      #2 drive(tbl[i].a, tbl[i].b);
      @(negedge clock0);
      @(negedge clock0);
      check($sformatf("table_%0d", i), result, tbl[i].exp);
    end

    // Sequence 4: back-to-back sets must give results on consecutive cycles.
    drive({8'h05, 8'h03, 8'h01}, {8'h06, 8'h04, 8'h02});
    @(negedge clock0);
    drive({8'h02, 8'h02, 8'h02}, {8'h02, 8'h02, 8'h02});
    @(negedge clock0);
    check("b2b_first", result, 32'd44);
    @(negedge clock0);
    check("b2b_second", result, 32'd12);

    // Sequence 6: an async reset mid-stream must clear the result without a clock edge.
    drive(tbl[0].a, tbl[0].b);
    repeat (2) @(negedge clock0);
    check("pre_reset_nonzero", result, 32'h0000C000);
    @(posedge clock0);
    #2 resetn = 1'b0;
    #1 check("async_reset_clear", result, 32'h0);
    @(negedge clock0);
    check("reset_held", result, 32'h0);
    resetn = 1'b1;
    drive(ones, ones);
    @(negedge clock0);
    check("post_reset_edge1", result, 32'h0);
    @(negedge clock0);
    check("post_reset_edge2", result, 32'h00000003);

    // Randomized stream: a new set every cycle, checked against the model two cycles later.
    exp_hist.delete();
    for (int k = 0; k < 200; k++) begin
      for (int l = 0; l < 3; l++) begin
        ra[l] = 8'($urandom_range(0, 255));
        rb[l] = 8'($urandom_range(0, 255));
      end
      if (k % 50 == 0) begin
        ra = {8'h80, 8'h7F, 8'h80};
        rb = {8'h80, 8'h80, 8'h7F};
      end
      drive(ra, rb);
      exp_hist.push_back(ref_mac(ra, rb));
      @(negedge clock0);
      if (exp_hist.size() > 1) begin
        check($sformatf("random_%0d", k - 1), result, exp_hist.pop_front());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/c5_mac_8bit_x3.md
Name: c5_mac_8bit_x3

Overview:
Pipelined three-term signed multiply-accumulate: result = a0*b0 + a1*b1 + a2*b2.
Serves as the dot-product primitive for the sparse DNN accelerator's PE datapath, mapped to one Cyclone V DSP block in 9x9 mode.
Pure datapath: no handshake, one new operand set accepted every cycle.

Parameters:
A_WIDTH, 8, width of each dataa_n operand (two's complement)
B_WIDTH, 8, width of each datab_n operand (two's complement)
RESULT_WIDTH, 32, width of result; must be >= A_WIDTH+B_WIDTH+2
SIGNED, 1, 1 = operands signed two's complement; 0 = all operands unsigned

Ports:
clock0  in  1  sole clock; all registers rising-edge
resetn  in  1  asynchronous active-low reset; clears all pipeline registers
dataa_0  in  A_WIDTH  multiplicand, lane 0
dataa_1  in  A_WIDTH  multiplicand, lane 1
dataa_2  in  A_WIDTH  multiplicand, lane 2
datab_0  in  B_WIDTH  multiplier, lane 0
datab_1  in  B_WIDTH  multiplier, lane 1
datab_2  in  B_WIDTH  multiplier, lane 2
result  out  RESULT_WIDTH  registered sum of the three products

Behaviour:
- Reset: resetn low asynchronously clears the input registers and the output register. result = 0 while reset is held and until the first valid sum propagates.
- Stage 1, edge N: register all six operands.
- Stage 2, edge N+1: compute the three products from the stage-1 registers, sum them, and register the sum into result.
- Latency: 2 rising edges from operand presentation to result update.
- Throughput: 1 operand set per cycle; no enable, no stall, no valid signal.
- Arithmetic, SIGNED=1:
  - Each product is a full A_WIDTH+B_WIDTH signed product.
  - The sum is sign-extended to RESULT_WIDTH.
  - No overflow is possible at the default widths.
  - Range: -48768 (0xFFFF4180) to +49152 (0x0000C000).
- Arithmetic, SIGNED=0: zero-extension throughout; maximum 3*255*255 = 195075.
- Operands changing between edges have no effect; only values at the rising edge are sampled.
- Reset asserted mid-stream:
  - All in-flight data is discarded and result drops to 0 immediately (asynchronous).
  - After resetn deasserts, the first non-reset result appears 2 edges after the first sampled operand set.
  - Any result during those edges is 0, because the registers are cleared.
- No X propagation from reset: every register has a reset value of 0.

Test Plan:
1. Reset low, all operands 0x00 -> result 0. Release reset, drive all operands 0x01 -> result 0x00000003 exactly 2 rising edges after the first edge sampling 0x01; result 0 before that.
2. All six operands 0x80 (-128) -> result 0x0000C000 (49152) after 2 edges.
3. All dataa = 0x7F, all datab = 0x80 -> result 0xFFFF4180 (-48768).
4. Back-to-back sets on consecutive edges: (1,2),(3,4),(5,6) on all lanes, then (2,2),(2,2),(2,2) -> result sequence 0x2C (44), then 0x0C (12) on consecutive cycles, confirming 1/cycle throughput.
5. Mixed signs: a = {0x05, 0xFD, 0x00}, b = {0x04, 0x03, 0x7F} -> 20 - 9 + 0 = 0x0000000B.
6. With a nonzero result pipeline in flight, pulse resetn low between edges -> result goes to 0 without waiting for a clock edge. After release, steady operands 0x01 -> 0x00000003 after 2 edges.
